// File: rtl/rx_flow_fifo_if.sv
// rtl/rx_flow_fifo_if.sv - stream bundle for rx_flow_fifo
// Purpose: groups the receive, consumer, keyboard and transmit valid/ready
// streams plus the status outputs of rx_flow_fifo.
// Signals:
//   in_data/in_valid/in_ready      host-link receive stream into the buffer
//   out_data/out_valid/out_ready   buffered stream towards command_handler
//   kbd_data/kbd_valid/kbd_ready   keyboard bytes heading to the host
//   tx_data/tx_valid/tx_ready      byte stream to the host-link transmitter
//   level, flow_stopped            fill count and XOFF-in-effect status
// Modports: slave = the buffer itself, master = the surrounding logic.
interface rx_flow_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_BITS = 6
);
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          kbd_data;
  logic                kbd_valid;
  logic                kbd_ready;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [DEPTH_BITS:0] level;
  logic                flow_stopped;

  modport slave (
    input  in_data, in_valid, out_ready, kbd_data, kbd_valid, tx_ready,
    output in_ready, out_data, out_valid, kbd_ready, tx_data, tx_valid,
           level, flow_stopped
  );

  modport master (
    output in_data, in_valid, out_ready, kbd_data, kbd_valid, tx_ready,
    input  in_ready, out_data, out_valid, kbd_ready, tx_data, tx_valid,
           level, flow_stopped
  );
endinterface

// File: rtl/rx_flow_fifo.sv
// rtl/rx_flow_fifo.sv - receive buffer with XON/XOFF software flow control
// Purpose: buffers host-link words for command_handler and, when the buffer
// fills, injects XOFF (0x13) into the keyboard-to-host stream, then XON
// (0x11) once it drains.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    rx_flow_fifo_if.slave (in_*, out_*, kbd_*, tx_*, level,
//          flow_stopped)
// Configuration: define RX_FLOW_CTRL_EN to build the flow-control FSM;
// without it the tx register carries keyboard bytes only and
// flow_stopped is tied low.
module rx_flow_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_BITS = 6,
  parameter int XOFF_LEVEL = 48,
  parameter int XON_LEVEL  = 16
) (
  input  logic         clk,
  input  logic         reset,
  rx_flow_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_LVL = (DEPTH_BITS+1)'(DEPTH);

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]   level_q, level_d, ram_cnt;
  logic [DATA_W-1:0]     out_data_q;
  logic                  out_valid_q;
  logic                  wr_en, rd_xfer, fetch;

  assign bus.in_ready = (level_q != FULL_LVL);
  assign wr_en        = bus.in_valid && bus.in_ready;
  assign rd_xfer      = out_valid_q && bus.out_ready;
  // level includes the word sitting in the output register; the rest is RAM
  assign ram_cnt      = level_q - {{DEPTH_BITS{1'b0}}, out_valid_q};
  // refill the output register whenever it is empty or being consumed
  assign fetch        = (ram_cnt != '0) && (!out_valid_q || bus.out_ready);

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_xfer})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      level_q <= level_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (fetch) begin
        out_data_q  <= mem_q[rd_ptr_q];
        out_valid_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + 1'b1;
      end else if (rd_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.level     = level_q;

  // ---------------- Tx register ----------------
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       kbd_ready;
  logic       load_ok;

  assign load_ok = !tx_valid_q || bus.tx_ready;

`ifdef RX_FLOW_CTRL_EN
  localparam logic [DEPTH_BITS:0] XOFF_LVL = (DEPTH_BITS+1)'(XOFF_LEVEL);
  localparam logic [DEPTH_BITS:0] XON_LVL  = (DEPTH_BITS+1)'(XON_LEVEL);
  localparam logic [7:0] XOFF_CHAR = 8'h13;
  localparam logic [7:0] XON_CHAR  = 8'h11;

  typedef enum logic [1:0] {FLOWING, XOFF_PEND, STOPPED, XON_PEND} state_e;
  state_e     state_q, state_d;
  // set while the pending control byte occupies the tx register
  logic       ctrl_loaded_q, ctrl_loaded_d;
  logic       load_ctrl;
  logic [7:0] ctrl_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FLOWING;
      ctrl_loaded_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_loaded_q <= ctrl_loaded_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ctrl_loaded_d = ctrl_loaded_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    kbd_ready     = 1'b0;
    load_ctrl     = 1'b0;
    ctrl_byte     = XOFF_CHAR;

    case (state_q)
      FLOWING: begin
        if (level_q >= XOFF_LVL) state_d = XOFF_PEND;
      end
      XOFF_PEND: begin
        if (!ctrl_loaded_q) begin
          // drained again before XOFF got out: forget it, nothing to undo
          if (level_q <= XON_LVL) begin
            state_d = FLOWING;
          end else if (load_ok) begin
            load_ctrl = 1'b1;
            ctrl_byte = XOFF_CHAR;
          end
        end else if (tx_valid_q && bus.tx_ready) begin
          state_d       = STOPPED;
          ctrl_loaded_d = 1'b0;
        end
      end
      STOPPED: begin
        if (level_q <= XON_LVL) state_d = XON_PEND;
      end
      XON_PEND: begin
        if (!ctrl_loaded_q) begin
          if (load_ok) begin
            load_ctrl = 1'b1;
            ctrl_byte = XON_CHAR;
          end
        end else if (tx_valid_q && bus.tx_ready) begin
          state_d       = FLOWING;
          ctrl_loaded_d = 1'b0;
        end
      end
      default: state_d = FLOWING;
    endcase

    // control byte wins the load slot over the keyboard
    if (load_ctrl) begin
      tx_valid_d    = 1'b1;
      tx_data_d     = ctrl_byte;
      ctrl_loaded_d = 1'b1;
    end else if (load_ok) begin
      if (bus.kbd_valid) begin
        tx_valid_d = 1'b1;
        tx_data_d  = bus.kbd_data;
        kbd_ready  = 1'b1;
      end else begin
        tx_valid_d = 1'b0;
      end
    end
  end

  assign bus.flow_stopped = (state_q == STOPPED) || (state_q == XON_PEND);
`else
  logic unused_levels;
  assign unused_levels = ^{32'(XOFF_LEVEL), 32'(XON_LEVEL)};

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    kbd_ready  = 1'b0;
    if (load_ok) begin
      tx_valid_d = bus.kbd_valid;
      if (bus.kbd_valid) begin
        tx_data_d = bus.kbd_data;
        kbd_ready = 1'b1;
      end
    end
  end

  assign bus.flow_stopped = 1'b0;
`endif

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.kbd_ready = kbd_ready;

endmodule

// File: doc/rx_flow_fifo.md
# rx_flow_fifo

Parametrised receive buffer with software flow control for the terminal's host link. It sits between the UART/USB-serial output stream and `command_handler`, and absorbs bursts while `command_handler` is busy with scrolls and clears. When the buffer fills it injects XOFF (0x13) into the keyboard-to-host transmit stream, and it sends XON (0x11) once the buffer drains.

## Interface
Parameters:
- `DATA_W`, 8: width of received words.
- `DEPTH_BITS`, 6: buffer depth is 2**DEPTH_BITS entries.
- `XOFF_LEVEL`, 48: fill level at which XOFF is requested. Must satisfy XON_LEVEL < XOFF_LEVEL <= 2**DEPTH_BITS.
- `XON_LEVEL`, 16: fill level at or below which XON is requested.

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk`  in  1  system clock (48 MHz domain).
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  DATA_W  received word from host link.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  buffer can accept a word.
- `out_data`  out  DATA_W  oldest buffered word, to `command_handler`.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts the word.
- `kbd_data`  in  8  keyboard byte.
- `kbd_valid`  in  1  keyboard byte valid.
- `kbd_ready`  out  1  keyboard byte accepted.
- `tx_data`  out  8  byte to host link transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte.
- `level`  out  DEPTH_BITS+1  current fill count.
- `flow_stopped`  out  1  high while the host has been sent XOFF and no XON yet.

## Operation
- **Handshakes.** All streams are valid/ready.
  - A transfer occurs on a rising edge where both valid and ready are high.
  - Once a valid is asserted, its data is held stable until the transfer completes.
- **FIFO.**
  - `in_ready = (level != 2**DEPTH_BITS)`.
  - Write and read in the same cycle leave `level` unchanged.
  - There is no bypass: a write into an empty buffer is not visible on `out_*` in the same cycle.
  - Pointers wrap modulo 2**DEPTH_BITS.
  - `level` counts 0 to 2**DEPTH_BITS inclusive.
- **Tx register.**
  - `tx_data`/`tx_valid` are registered. The register is loaded when empty, or in the same cycle its current byte transfers.
  - Load priority: pending control byte (XOFF/XON) first, then keyboard.
  - `kbd_ready` is high only in cycles where the keyboard byte is loaded.
- **Flow-control FSM.** States: FLOWING, XOFF_PEND, STOPPED, XON_PEND.
  - FLOWING → XOFF_PEND when `level >= XOFF_LEVEL`.
  - XOFF_PEND: 0x13 is loaded into the tx register at the first load opportunity. The FSM moves to STOPPED on that byte's tx transfer.
  - XOFF_PEND → FLOWING if `level <= XON_LEVEL` before 0x13 is loaded. Once loaded, the byte completes.
  - STOPPED → XON_PEND when `level <= XON_LEVEL`.
  - XON_PEND: 0x11 is loaded at the first load opportunity. The FSM moves to FLOWING on its tx transfer.
  - `flow_stopped` = 1 in STOPPED and XON_PEND.
- **Host overrun.** If the host ignores XOFF, `in_ready` still backpressures at full. No data is dropped.

## Timing
- **Reset values:** `out_valid`=0, `tx_valid`=0, `tx_data`=0, `kbd_ready`=0, `level`=0, `flow_stopped`=0, FSM=FLOWING, `in_ready`=1 from the cycle after reset.
- **FIFO latency.** A word written at edge N gives `out_valid`=1 after edge N+1 (one-cycle read latency from RAM). After that, back-to-back reads sustain one word per cycle.
- **`level` updates** on the edge of the transfer.
- **FSM transitions** are evaluated on registered `level`. XOFF is requested on the cycle after the edge that made `level` reach XOFF_LEVEL.
- **Control byte in tx.** A control byte appears on `tx_valid` at most 1 cycle after the request when the tx register is empty. Otherwise it appears in the cycle after the in-flight byte transfers.
- **Full throughput.** Continuous `tx_ready`=1 sustains one tx byte per cycle.
- **Reset mid-operation.** Reset clears the buffer contents and any pending or in-flight control byte. The FSM returns to FLOWING, so no XON is sent.

## Configuration
- **`RX_FLOW_CTRL_EN` defined:** the full behaviour above.
- **`RX_FLOW_CTRL_EN` undefined:**
  - The FSM and control-byte injection are removed.
  - The tx register passes keyboard bytes only.
  - `flow_stopped` is tied 0.
  - XOFF_LEVEL and XON_LEVEL are unused.
  - FIFO behaviour is unchanged.

## Test plan
- **Basic pass-through.** After reset, write 0x41, 0x42, 0x43 with `out_ready`=1 → `out_data` is 0x41, 0x42, 0x43 in order; `level` returns to 0; `tx_valid` stays 0.
- **Full buffer.** With `out_ready`=0, write 64 words (DEPTH_BITS=6) → `level`=64, `in_ready`=0; a 65th word is held, not lost.
- **XOFF/XON cycle.** With `out_ready`=0, fill to 48 → exactly one 0x13 on tx, `flow_stopped`=1. Then drain to 16 → exactly one 0x11, `flow_stopped`=0.
- **Priority against keyboard.** Hold `kbd_valid`=1 with 0x61 and `tx_ready`=0 while XOFF becomes pending → the in-flight keyboard byte completes first, then 0x13, then 0x61 from the next keyboard byte. No keyboard byte is lost.
- **XOFF cancellation.** Reach level 48 while `tx_ready`=0 with the tx register occupied, then drain to 16 before the register frees → no 0x13 and no 0x11 are sent.
- **Mid-operation reset.** Assert reset in STOPPED with `level`=40 → next cycle `level`=0, `out_valid`=0, `tx_valid`=0, `flow_stopped`=0, no XON emitted.
